// File: rtl/ped_crossing_scheduler.sv
// Car/pedestrian phase sequencer for the traffic-light controller. It latches crosswalk
// requests and serves one crosswalk per pedestrian cycle in round-robin order.
module ped_crossing_scheduler #(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 6,
  parameter int unsigned FLASH_T   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       run,
  input  logic [3:0] req_pulse,
  output logic [2:0] phase,
  output logic [3:0] sec_left,
  output logic [3:0] walk_grant,
  output logic [3:0] pending,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    StCarGreen  = 3'd0,
    StCarYellow = 3'd1,
    StAllRed1   = 3'd2,
    StPedWalk   = 3'd3,
    StPedFlash  = 3'd4,
    StAllRed2   = 3'd5
  } phase_e;

  localparam logic [3:0] GreenDur  = 4'(GREEN_MIN);
  localparam logic [3:0] YellowDur = 4'(YELLOW_T);
  localparam logic [3:0] AllRedDur = 4'(ALLRED_T);
  localparam logic [3:0] WalkDur   = 4'(WALK_T);
  localparam logic [3:0] FlashDur  = 4'(FLASH_T);

  phase_e     phase_q, phase_d;
  logic [3:0] sec_left_q, sec_left_d;
  logic [3:0] walk_grant_q, walk_grant_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] ptr_q, ptr_d;
  logic       phase_start_q, phase_start_d;

  phase_e     next_phase;
  logic       can_exit;
  logic       illegal;
  logic [3:0] req_mask;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] search_idx;

  function automatic logic [3:0] dur_of(input phase_e p);
    logic [3:0] d;
    case (p)
      StCarGreen:  d = GreenDur;
      StCarYellow: d = YellowDur;
      StAllRed1:   d = AllRedDur;
      StPedWalk:   d = WalkDur;
      StPedFlash:  d = FlashDur;
      StAllRed2:   d = AllRedDur;
      default:     d = GreenDur;
    endcase
    return d;
  endfunction

  // Round-robin search starting just after the last served crosswalk.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = ptr_q;
    search_idx = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      search_idx = ptr_q + 2'(k);
      if (!win_found && pending_q[search_idx]) begin
        win_found = 1'b1;
        win_idx   = search_idx;
      end
    end
  end

  always_comb begin
    next_phase = phase_q;
    can_exit   = 1'b1;
    illegal    = 1'b0;
    case (phase_q)
      StCarGreen: begin
        next_phase = StCarYellow;
        can_exit   = (pending_q != 4'b0000);
      end
      StCarYellow: next_phase = StAllRed1;
      StAllRed1:   next_phase = StPedWalk;
      StPedWalk:   next_phase = StPedFlash;
      StPedFlash:  next_phase = StAllRed2;
      StAllRed2:   next_phase = StCarGreen;
      default: begin
        next_phase = StCarGreen;
        illegal    = 1'b1;
      end
    endcase
  end

  always_comb begin
    phase_d       = phase_q;
    sec_left_d    = sec_left_q;
    walk_grant_d  = walk_grant_q;
    ptr_d         = ptr_q;
    phase_start_d = 1'b0;

    // The crosswalk being walked is already served; its button is ignored until flashing.
    req_mask  = (phase_q == StPedWalk) ? walk_grant_q : 4'b0000;
    pending_d = pending_q | (req_pulse & ~req_mask);

    if (illegal) begin
      phase_d       = StCarGreen;
      sec_left_d    = GreenDur;
      walk_grant_d  = 4'b0000;
      phase_start_d = 1'b1;
    end else if (run) begin
      if (sec_left_q == 4'd0 && can_exit) begin
        phase_d       = next_phase;
        sec_left_d    = dur_of(next_phase);
        phase_start_d = 1'b1;
        if (next_phase == StPedWalk) begin
          walk_grant_d = 4'b0000;
          if (win_found) begin
            walk_grant_d[win_idx] = 1'b1;
            pending_d[win_idx]    = 1'b0;
            ptr_d                 = win_idx;
          end
        end else if (next_phase == StAllRed2) begin
          walk_grant_d = 4'b0000;
        end
      end else if (tick_1hz && sec_left_q != 4'd0) begin
        sec_left_d = sec_left_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= StCarGreen;
      sec_left_q    <= GreenDur;
      walk_grant_q  <= 4'b0000;
      pending_q     <= 4'b0000;
      ptr_q         <= 2'd3;
      phase_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      sec_left_q    <= sec_left_d;
      walk_grant_q  <= walk_grant_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign phase       = phase_q;
  assign sec_left    = sec_left_q;
  assign walk_grant  = walk_grant_q;
  assign pending     = pending_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_ped_crossing_scheduler.sv
// Directed bench for ped_crossing_scheduler; each phase entry is checked against a queue of
// expected {phase, sec_left, walk_grant} records pushed ahead of the stimulus.
module tb_ped_crossing_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic       run;
  logic [3:0] req_pulse;
  logic [2:0] phase;
  logic [3:0] sec_left;
  logic [3:0] walk_grant;
  logic [3:0] pending;
  logic       phase_start;

  int checks   = 0;
  int errors   = 0;
  int ps_count = 0;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] sl;
    logic [3:0] wg;
  } exp_t;

  exp_t exp_q[$];

  always #20 clk = ~clk;

  ped_crossing_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .run        (run),
    .req_pulse  (req_pulse),
    .phase      (phase),
    .sec_left   (sec_left),
    .walk_grant (walk_grant),
    .pending    (pending),
    .phase_start(phase_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
      cyc(2);
    end
  endtask

  task automatic pulse(input logic [3:0] r);
    req_pulse = r;
    cyc(1);
    req_pulse = 4'b0000;
  endtask

  task automatic push(input logic [2:0] ph, input logic [3:0] sl, input logic [3:0] wg);
    exp_t e;
    e.ph = ph;
    e.sl = sl;
    e.wg = wg;
    exp_q.push_back(e);
  endtask

  // Pushes one full pedestrian cycle, then runs green out and stops on WALK entry.
  task automatic to_walk(input logic [3:0] req, input logic [3:0] g, input logic [3:0] pend);
    int n;
    push(3'd1, 4'd3, 4'b0000);
    push(3'd2, 4'd1, 4'b0000);
    push(3'd3, 4'd6, g);
    push(3'd4, 4'd4, g);
    push(3'd5, 4'd1, 4'b0000);
    push(3'd0, 4'd8, 4'b0000);
    if (req != 4'b0000) pulse(req);
    n = 0;
    while (phase == 3'd0 && n < 20) begin
      tick_n(1);
      n++;
    end
    chk("green_exit", 32'(phase), 32'd1);
    chk("yellow_len", 32'(sec_left), 32'd3);
    tick_n(3);
    chk("allred1", 32'(phase), 32'd2);
    tick_n(1);
    chk("walk", 32'(phase), 32'd3);
    chk("walk_grant", 32'(walk_grant), 32'(g));
    chk("pending_after_grant", 32'(pending), 32'(pend));
  endtask

  task automatic from_walk(input logic [3:0] g);
    tick_n(6);
    chk("flash", 32'(phase), 32'd4);
    chk("flash_grant", 32'(walk_grant), 32'(g));
    tick_n(4);
    chk("allred2", 32'(phase), 32'd5);
    chk("allred2_grant", 32'(walk_grant), 32'd0);
    tick_n(1);
    chk("green_reload_phase", 32'(phase), 32'd0);
    chk("green_reload_sec", 32'(sec_left), 32'd8);
  endtask

  // Scoreboard consumer: every phase_start must match the next expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && phase_start === 1'b1) begin
        ps_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_phase_start", 32'(phase_start), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ps_phase", 32'(phase), 32'(e.ph));
          chk("ps_sec", 32'(sec_left), 32'(e.sl));
          chk("ps_grant", 32'(walk_grant), 32'(e.wg));
        end
      end
    end
  end

  initial begin
    int ps0;
    rst_n     = 1'b0;
    run       = 1'b1;
    tick_1hz  = 1'b0;
    req_pulse = 4'b0000;
    cyc(2);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_sec", 32'(sec_left), 32'd8);
    chk("rst_grant", 32'(walk_grant), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_phase_start", 32'(phase_start), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Green counts down and holds at zero with nothing pending.
    for (int i = 1; i <= 20; i++) begin
      tick_n(1);
      chk("t1_phase", 32'(phase), 32'd0);
      chk("t1_sec", 32'(sec_left), (i <= 8) ? 32'(8 - i) : 32'd0);
    end

    // Single request on L; green already expired.
    ps0 = ps_count;
    to_walk(4'b0100, 4'b0100, 4'b0000);
    from_walk(4'b0100);
    chk("t2_pulses", 32'(ps_count - ps0), 32'd6);

    // U and L together: pointer sits at L, so U wins first, then L.
    to_walk(4'b0101, 4'b0001, 4'b0100);
    from_walk(4'b0001);
    to_walk(4'b0000, 4'b0100, 4'b0000);
    from_walk(4'b0100);

    // Own-crosswalk request ignored in WALK, latched in FLASH.
    to_walk(4'b0010, 4'b0010, 4'b0000);
    pulse(4'b0010);
    chk("t4_walk_ignore", 32'(pending), 32'd0);
    tick_n(6);
    chk("t4_flash", 32'(phase), 32'd4);
    pulse(4'b0010);
    chk("t4_flash_latch", 32'(pending), 32'b0010);
    tick_n(5);
    chk("t4_green", 32'(phase), 32'd0);
    chk("t4_green_sec", 32'(sec_left), 32'd8);

    // Freeze mid-WALK.
    to_walk(4'b0000, 4'b0010, 4'b0000);
    tick_n(2);
    chk("t5_sec_before", 32'(sec_left), 32'd4);
    run = 1'b0;
    tick_n(5);
    chk("t5_frozen_sec", 32'(sec_left), 32'd4);
    chk("t5_frozen_phase", 32'(phase), 32'd3);
    chk("t5_frozen_grant", 32'(walk_grant), 32'b0010);
    run = 1'b1;
    tick_n(1);
    chk("t5_resume_sec", 32'(sec_left), 32'd3);
    tick_n(3);
    chk("t5_flash", 32'(phase), 32'd4);

    // Asynchronous reset mid-FLASH with a request pending.
    tick_n(2);
    chk("t6_flash_sec", 32'(sec_left), 32'd2);
    pulse(4'b1000);
    chk("t6_pending", 32'(pending), 32'b1000);
    chk("t6_queue_left", 32'(exp_q.size()), 32'd2);
    #7;
    rst_n = 1'b0;
    #1;
    chk("t6_phase", 32'(phase), 32'd0);
    chk("t6_sec", 32'(sec_left), 32'd8);
    chk("t6_grant", 32'(walk_grant), 32'd0);
    chk("t6_pending_clr", 32'(pending), 32'd0);
    chk("t6_phase_start", 32'(phase_start), 32'd0);
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
